i2c_slave: RTL and testbench

Single-address I2C target (responder) for the 100 kHz bus driven by the team's I2C master. It oversamples SCL/SDA on the 100 MHz system clock, detects START/STOP, matches a 7-bit address, receives write bytes and transmits read bytes through a simple byte handshake to local logic. SDA is open-drain; the block never drives SCL and does not stretch the clock.

---
 rtl/i2c_slave.sv | 170 +++++++++++++++++
 tb/tb_i2c_slave.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave.sv
// Single-address I2C target: oversampled SCL/SDA, START/STOP detection, address match,
// byte receive with ACK and byte transmit through a tx_req/tx_data handshake.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sda,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       nack_seen
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, WAIT_STOP
  } state_t;

  state_t     state;
  logic       sda_oe;
  logic       scl_p0, scl_p1, scl_p2;
  logic       sda_p0, sda_p1, sda_p2;
  logic [2:0] bitcnt;
  logic [7:0] shreg;
  logic       rw;
  logic       ack_ph;

  assign sda = sda_oe ? 1'b0 : 1'bz;

  // p0/p1 synchronize, p2 is history; edges compare the last two synchronized samples
  logic scl_rise, scl_fall, sda_rise, sda_fall, start_det, stop_det;
  assign scl_rise  = scl_p1 & ~scl_p2;
  assign scl_fall  = ~scl_p1 & scl_p2;
  assign sda_rise  = sda_p1 & ~sda_p2;
  assign sda_fall  = ~sda_p1 & sda_p2;
  assign start_det = sda_fall & scl_p1 & scl_p2;
  assign stop_det  = sda_rise & scl_p1 & scl_p2;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_p0    <= 1'b1;
      scl_p1    <= 1'b1;
      scl_p2    <= 1'b1;
      sda_p0    <= 1'b1;
      sda_p1    <= 1'b1;
      sda_p2    <= 1'b1;
      state     <= IDLE;
      sda_oe    <= 1'b0;
      tx_req    <= 1'b0;
      rx_valid  <= 1'b0;
      rx_data   <= 8'h00;
      busy      <= 1'b0;
      nack_seen <= 1'b0;
      bitcnt    <= 3'd7;
      rw        <= 1'b0;
      ack_ph    <= 1'b0;
    end else begin
      scl_p0   <= scl;
      scl_p1   <= scl_p0;
      scl_p2   <= scl_p1;
      sda_p0   <= sda;
      sda_p1   <= sda_p0;
      sda_p2   <= sda_p1;
      tx_req   <= 1'b0;
      rx_valid <= 1'b0;
      if (start_det) begin
        state  <= ADDR;
        bitcnt <= 3'd7;
        busy   <= 1'b0;
        sda_oe <= 1'b0;
        ack_ph <= 1'b0;
      end else if (stop_det) begin
        state  <= IDLE;
        busy   <= 1'b0;
        sda_oe <= 1'b0;
        ack_ph <= 1'b0;
      end else begin
        case (state)
          IDLE: ;
          ADDR: begin
            if (scl_rise) begin
              shreg <= {shreg[6:0], sda_p1};
              if (bitcnt == 3'd0) begin
                // shreg[6:0] already holds the seven address bits; sda_p1 is R/W
                if (shreg[6:0] == SLAVE_ADDR) begin
                  state     <= ADDR_ACK;
                  rw        <= sda_p1;
                  busy      <= 1'b1;
                  nack_seen <= 1'b0;
                  tx_req    <= sda_p1;
                end else begin
                  state <= WAIT_STOP;
                end
              end else begin
                bitcnt <= bitcnt - 3'd1;
              end
            end
          end
          ADDR_ACK, RX_ACK: begin
            if (scl_fall) begin
              if (!ack_ph) begin
                sda_oe <= 1'b1;
                ack_ph <= 1'b1;
              end else begin
                ack_ph <= 1'b0;
                bitcnt <= 3'd7;
                if (state == ADDR_ACK && rw) begin
                  shreg  <= tx_data;
                  sda_oe <= ~tx_data[7];
                  state  <= TX;
                end else begin
                  sda_oe <= 1'b0;
                  state  <= RX;
                end
              end
            end
          end
          RX: begin
            if (scl_rise) begin
              shreg <= {shreg[6:0], sda_p1};
              if (bitcnt == 3'd0) begin
                rx_data  <= {shreg[6:0], sda_p1};
                rx_valid <= 1'b1;
                state    <= RX_ACK;
              end else begin
                bitcnt <= bitcnt - 3'd1;
              end
            end
          end
          TX: begin
            // bitcnt 7..1 present bits 6..0; the fall seen at bitcnt 0 releases for the ACK slot
            if (scl_fall) begin
              if (bitcnt == 3'd0) begin
                sda_oe <= 1'b0;
                state  <= TX_ACK;
              end else begin
                sda_oe <= ~shreg[6];
                shreg  <= {shreg[6:0], 1'b0};
                bitcnt <= bitcnt - 3'd1;
              end
            end
          end
          TX_ACK: begin
            if (scl_rise && !ack_ph) begin
              if (!sda_p1) begin
                tx_req <= 1'b1;
                ack_ph <= 1'b1;
              end else begin
                nack_seen <= 1'b1;
                state     <= WAIT_STOP;
              end
            end else if (scl_fall && ack_ph) begin
              ack_ph <= 1'b0;
              shreg  <= tx_data;
              sda_oe <= ~tx_data[7];
              bitcnt <= 3'd7;
              state  <= TX;
            end
          end
          WAIT_STOP: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: a clock-counted bus master drives directed and randomized
// transactions; a transaction-level model predicts ACKs, received and read bytes.
module tb_i2c_slave;
  localparam int Q = 10;
  localparam logic [6:0] SADDR = 7'h50;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       m_low = 1'b0;
  logic [7:0] tx_data = 8'h00;
  wire        sda;
  logic       tx_req, rx_valid, busy, nack_seen;
  logic [7:0] rx_data;

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  i2c_slave #(.SLAVE_ADDR(SADDR)) dut (
    .clk(clk), .rst(rst), .scl(scl), .sda(sda), .tx_data(tx_data),
    .tx_req(tx_req), .rx_data(rx_data), .rx_valid(rx_valid),
    .busy(busy), .nack_seen(nack_seen)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int txreq_cnt = 0;
  int slave_low_cnt = 0;
  logic [7:0] rx_log[$];
  logic [7:0] exp_rx[$];
  logic [7:0] tx_q[$];

  // local logic model: log write bytes, hand out the next read byte on each tx_req
  always @(negedge clk) begin
    if (rx_valid) rx_log.push_back(rx_data);
    if (tx_req) begin
      txreq_cnt++;
      if (tx_q.size() > 0) tx_data = tx_q.pop_front();
      else tx_data = 8'hFF;
    end
    if (!m_low && sda === 1'b0) slave_low_cnt++;
  end

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wq();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bit_cycle(input logic drive_low, output logic sampled);
    m_low = drive_low; wq();
    scl = 1'b1; wq();
    sampled = sda; wq();
    scl = 1'b0; wq();
  endtask

  task automatic start_c();
    m_low = 1'b0; wq();
    scl = 1'b1; wq();
    m_low = 1'b1; wq();
    scl = 1'b0; wq();
  endtask

  task automatic stop_c();
    m_low = 1'b1; wq();
    scl = 1'b1; wq();
    m_low = 1'b0; wq(); wq();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_cycle(~b[i], s);
    bit_cycle(1'b0, ack);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] b);
    logic s;
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      bit_cycle(1'b0, s);
      b = {b[6:0], s};
    end
    bit_cycle(~nack, s);
  endtask

  task automatic check_rx(input string tag);
    chk({tag, "_rxcnt"}, rx_log.size(), exp_rx.size());
    for (int i = 0; i < exp_rx.size() && i < rx_log.size(); i++)
      chk({tag, "_rxbyte"}, rx_log[i], exp_rx[i]);
  endtask

  task automatic do_write(input logic [6:0] addr, input logic [7:0] bytes[$], input string tag);
    logic a;
    bit   hit;
    hit = (addr == SADDR);
    start_c();
    send_byte({addr, 1'b0}, a);
    chk({tag, "_addr_ack"}, a, hit ? 0 : 1);
    chk({tag, "_busy"}, busy, hit ? 1 : 0);
    foreach (bytes[i]) begin
      send_byte(bytes[i], a);
      chk({tag, "_data_ack"}, a, hit ? 0 : 1);
      if (hit) exp_rx.push_back(bytes[i]);
    end
  endtask

  task automatic do_read(input logic [7:0] bytes[$], input string tag);
    logic a;
    logic [7:0] got;
    int n0;
    foreach (bytes[i]) tx_q.push_back(bytes[i]);
    n0 = txreq_cnt;
    start_c();
    send_byte({SADDR, 1'b1}, a);
    chk({tag, "_addr_ack"}, a, 0);
    chk({tag, "_nack_clr"}, nack_seen, 0);
    foreach (bytes[i]) begin
      recv_byte(i == bytes.size() - 1, got);
      chk({tag, "_byte"}, got, bytes[i]);
    end
    chk({tag, "_txreq"}, txreq_cnt - n0, bytes.size());
    chk({tag, "_nack_seen"}, nack_seen, 1);
    chk({tag, "_sda_rel"}, sda, 1);
  endtask

  task automatic finish_txn(input string tag);
    stop_c();
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_sda_end"}, sda, 1);
    check_rx(tag);
  endtask

  initial begin
    logic [7:0] bq[$];
    logic s;
    int kind, len;
    logic [6:0] ra;

    repeat (4) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_rx_valid", rx_valid, 0);
    chk("reset_tx_req", tx_req, 0);
    chk("reset_rx_data", rx_data, 0);
    chk("reset_nack", nack_seen, 0);
    chk("reset_sda", sda, 1);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    bq = {8'hA5};
    do_write(SADDR, bq, "wr_a5");
    finish_txn("wr_a5");

    slave_low_cnt = 0;
    bq = {8'h11};
    do_write(7'h42, bq, "mismatch");
    finish_txn("mismatch");
    chk("mismatch_sda_oe", slave_low_cnt, 0);

    bq = {8'h3C};
    do_read(bq, "rd_nack");
    finish_txn("rd_nack");

    bq = {8'h3C, 8'hC3};
    do_read(bq, "rd_two");
    finish_txn("rd_two");

    bq = {8'h01, 8'h02, 8'h03};
    do_write(SADDR, bq, "wr_multi");
    check_rx("wr_multi");
    bq = {8'h5A};
    do_read(bq, "sr_read");
    finish_txn("sr_read");

    bq = {};
    do_write(SADDR, bq, "abort");
    for (int i = 0; i < 4; i++) bit_cycle(i[0], s);
    stop_c();
    chk("abort_busy", busy, 0);
    chk("abort_sda", sda, 1);
    check_rx("abort");

    for (int it = 0; it < 5; it++) begin
      kind = $urandom_range(0, 2);
      len  = $urandom_range(1, 3);
      bq = {};
      for (int j = 0; j < len; j++) bq.push_back(8'($urandom_range(0, 255)));
      if (kind == 0) begin
        do_write(SADDR, bq, "rnd_wr");
      end else if (kind == 1) begin
        do_read(bq, "rnd_rd");
      end else begin
        ra = 7'($urandom_range(0, 127));
        if (ra == SADDR) ra = 7'h51;
        do_write(ra, bq, "rnd_miss");
      end
      finish_txn("rnd");
    end

    // reset while the slave holds the address ACK low
    start_c();
    for (int i = 7; i >= 0; i--) begin
      bq = {{SADDR, 1'b0}};
      bit_cycle(~bq[0][i], s);
    end
    m_low = 1'b0; wq();
    scl = 1'b1; wq();
    chk("rst_ack_driven", sda, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_sda_rel", sda, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_nack", nack_seen, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_tx_req", tx_req, 0);
    @(negedge clk);
    rst = 1'b0;
    wq();
    scl = 1'b0; wq();
    stop_c();

    bq = {8'h77};
    do_write(SADDR, bq, "post_rst");
    finish_txn("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
